alu_seq: RTL and testbench
==========================

# alu_seq

Parametrised, handshaked successor to the 4-bit combinational ALU. It keeps the same operand-inversion, carry-in and function-select encoding, and adds the following:
- WIDTH-bit operands.
- A registered result with a valid/ready output handshake.
- A zero flag.
- An optional multi-cycle unsigned shift-add multiplier.

It sits between the operand/op issue logic and the result writeback stage.

## Interface
- WIDTH, default 8: operand and result width, minimum 2.

Ports:
- clk  in  1  sole clock; all state updates on rising edge.
- rst  in  1  synchronous reset, active high.
- in_valid  in  1  op/a/b presented.
- in_ready  out  1  block can accept; transfer when in_valid && in_ready at a clk edge.
- op  in  5  op[4] selects multiply; op[3] inverts a; op[2] inverts b and drives carry-in; op[1:0] selects the function: 00 AND, 01 OR, 10 XOR, 11 ADD.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- out_valid  out  1  result registers hold an unconsumed result.
- out_ready  in  1  consumer accepts; result consumed when out_valid && out_ready at an edge.
- y  out  WIDTH  result, or low half of the product.
- y_hi  out  WIDTH  high half of the product; 0 for non-multiply ops.
- cout  out  1  adder carry-out when op[1:0]==11, else 0.
- neg  out  1  ~carry & op[2] when op[1:0]==11, else 0; signals a negative unsigned difference.
- zero  out  1  y==0 (and y_hi==0 for multiply).

## Operation
Basic op (op[4]=0):
- am = op[3] ? ~a : a
- bm = op[2] ? ~b : b
- {cout,sum} = am + bm + op[2], computed at WIDTH+1 bits.
- y is selected by op[1:0].
- Subtract a-b is op=00111.

Multiply (op[4]=1, macro defined):
- Unsigned a*b, 2*WIDTH-bit product.
- Result is {y_hi,y}; cout=0, neg=0.
- op[3:0] is ignored.

FSM:
- IDLE: in_ready = !out_valid || out_ready.
  - On accept of a basic op, compute and load the result registers, set out_valid, stay in IDLE.
  - On accept of a multiply, latch a and b, clear the accumulator and counter, go to MUL.
- MUL: in_ready=0. Runs one shift-add iteration per cycle, examining multiplier bit i on cycle i. After WIDTH iterations it loads the result, sets out_valid and returns to IDLE.
  - out_valid is already clear on entry, because the accept condition guaranteed it.

Handshake and boundaries:
- While out_valid && !out_ready, y/y_hi/flags/out_valid hold stable and in_ready=0.
- Simultaneous consume and accept in IDLE:
  - For a basic op, the new result replaces the old one and out_valid stays 1.
  - For a multiply, out_valid drops to 0 while MUL runs.
- Reset has priority over everything. A reset during MUL aborts the multiply, and no result is produced.
- Carry wraps at WIDTH bits. No overflow flag is produced.

## Timing
Reset values: state=IDLE, out_valid=0, y=0, y_hi=0, cout=0, neg=0, zero=0, counter=0. in_ready=1 in the cycle after reset deasserts.

Latency:
- Basic op accepted at edge k: out_valid is high after edge k. Latency is 1 cycle.
- Multiply accepted at edge k: iterations run at edges k+1 to k+WIDTH, and out_valid is high after edge k+WIDTH.

Throughput:
- Basic ops: one per cycle with out_ready held high.
- Multiply: one per WIDTH+1 cycles.

in_ready is combinational from state, out_valid and out_ready only. There is no path from in_valid or op.

## Configuration
ALU_SEQ_MUL_EN:
- Defined: multiply datapath, MUL state and counter are compiled in, with the behaviour above.
- Undefined: op[4] is ignored and every op is a 1-cycle basic op. y_hi is tied to 0, and MUL is unreachable and absent.

## Test plan
All scenarios use WIDTH=8.
- Add: op=00011, a=7F, b=01. Response: next cycle out_valid=1, y=80, cout=0, neg=0, zero=0, y_hi=00.
- Subtract: op=00111, a=03, b=05. Response: y=FE, cout=0, neg=1. Then a=05, b=03: y=02, cout=1, neg=0.
- Logic and zero: op=00010, a=b=A5. Response: y=00, zero=1. Then op=01000, a=0F, b=33: y=F0 & 33 = 30, cout=0.
- Multiply (macro on): op=10000, a=FF, b=FF. Response: in_ready=0 for 8 cycles, then out_valid=1, y_hi=FE, y=01, zero=0. With the macro off, the same op yields y=FF (AND) after 1 cycle.
- Backpressure: result pending with out_ready=0 for 3 cycles. Response: outputs stable and in_ready=0 throughout. Then out_ready=1 together with a new add (a=01, b=01) in the same cycle: the new y=02 is valid on the next cycle, with no bubble.
- Reset mid-multiply: assert rst at the 3rd MUL cycle. Response: out_valid stays 0, all outputs are 0 after that edge, and in_ready=1 once rst deasserts.

Source files
------------

// File: rtl/alu_seq.sv
`default_nettype none
// ============================================================================
//  Module      : alu_seq
//  Description : Parametrised, handshaked ALU. Keeps the 4-bit combinational
//                ALU's op encoding (op[3] inverts a, op[2] inverts b and
//                drives carry-in, op[1:0] = AND/OR/XOR/ADD). The result is
//                registered behind a valid/ready output handshake, and a
//                zero flag is added. An optional multi-cycle unsigned
//                shift-add multiplier is selected by op[4].
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Configuration macro:
//    ALU_SEQ_MUL_EN  defined   : multiply datapath, MUL state and counter
//                                are present; op[4]=1 selects multiply.
//                    undefined : op[4] is ignored, every op takes 1 cycle,
//                                and y_hi is tied to 0.
//  Parameters:
//    WIDTH      operand/result width (minimum 2)
//  Ports:
//    clk        in   rising-edge clock
//    rst        in   synchronous reset, active high
//    in_valid   in   op/a/b presented
//    in_ready   out  block can accept (from state/out_valid/out_ready only)
//    op[4:0]    in   operation select
//    a, b       in   operands
//    out_valid  out  result registers hold an unconsumed result
//    out_ready  in   consumer accepts the result
//    y          out  result, or low half of the product
//    y_hi       out  high half of the product, 0 for basic ops
//    cout       out  adder carry-out (ADD only)
//    neg        out  negative unsigned difference (ADD with op[2] only)
//    zero       out  result (including y_hi) is zero
// ============================================================================
module alu_seq #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [4:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic [WIDTH-1:0] y_hi,
    output logic             cout,
    output logic             neg,
    output logic             zero
);

    // ------------------------------------------------------------------
    // Result registers
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] r_y;
    logic             r_cout;
    logic             r_neg;
    logic             r_zero;
    logic             r_out_valid;

    // ------------------------------------------------------------------
    // Basic (single-cycle) datapath
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] w_am;
    logic [WIDTH-1:0] w_bm;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH-1:0] w_basic_y;
    logic             w_basic_cout;
    logic             w_basic_neg;

    always_comb begin
        w_am         = op[3] ? ~a : a;
        w_bm         = op[2] ? ~b : b;
        // op[2] doubles as carry-in so that ~b + 1 forms the two's complement
        w_sum        = {1'b0, w_am} + {1'b0, w_bm} + {{WIDTH{1'b0}}, op[2]};
        w_basic_y    = w_sum[WIDTH-1:0];
        w_basic_cout = 1'b0;
        w_basic_neg  = 1'b0;
        case (op[1:0])
            2'b00:   w_basic_y = w_am & w_bm;
            2'b01:   w_basic_y = w_am | w_bm;
            2'b10:   w_basic_y = w_am ^ w_bm;
            default: begin
                w_basic_y    = w_sum[WIDTH-1:0];
                w_basic_cout = w_sum[WIDTH];
                // A subtract that produces no carry borrowed: a < b unsigned
                w_basic_neg  = ~w_sum[WIDTH] & op[2];
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Handshake
    // ------------------------------------------------------------------
    logic w_busy;
    logic w_accept;
    logic w_consume;

`ifdef ALU_SEQ_MUL_EN
    localparam logic [0:0] c_IDLE = 1'b0;
    localparam logic [0:0] c_MUL  = 1'b1;
    localparam int         c_CNT_W = $clog2(WIDTH);
    localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(WIDTH - 1);

    logic [0:0]         r_state;
    logic [c_CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0]   r_mcand;
    // Upper half is the accumulator, lower half the not-yet-examined
    // multiplier bits; each iteration shifts one multiplier bit out.
    logic [2*WIDTH-1:0] r_prod;
    logic [WIDTH-1:0]   r_y_hi;
    logic [WIDTH:0]     w_hi_sum;
    logic [2*WIDTH-1:0] w_prod_next;

    always_comb begin
        w_hi_sum    = {1'b0, r_prod[2*WIDTH-1:WIDTH]}
                    + (r_prod[0] ? {1'b0, r_mcand} : {(WIDTH+1){1'b0}});
        w_prod_next = {w_hi_sum, r_prod[WIDTH-1:1]};
    end

    assign w_busy = (r_state == c_MUL);
    assign y_hi   = r_y_hi;
`else
    logic w_unused_op4;

    assign w_busy       = 1'b0;
    assign y_hi         = {WIDTH{1'b0}};
    assign w_unused_op4 = op[4];
`endif

    assign in_ready  = !w_busy && (!r_out_valid || out_ready);
    assign w_accept  = in_valid && in_ready;
    assign w_consume = r_out_valid && out_ready;

    // ------------------------------------------------------------------
    // Control and result registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_y         <= '0;
            r_cout      <= 1'b0;
            r_neg       <= 1'b0;
            r_zero      <= 1'b0;
            r_out_valid <= 1'b0;
`ifdef ALU_SEQ_MUL_EN
            r_state     <= c_IDLE;
            r_cnt       <= '0;
            r_mcand     <= '0;
            r_prod      <= '0;
            r_y_hi      <= '0;
`endif
        end
`ifdef ALU_SEQ_MUL_EN
        else if (r_state == c_MUL) begin
            // in_ready is low here, so nothing can be accepted or consumed
            r_prod <= w_prod_next;
            r_cnt  <= r_cnt + c_CNT_W'(1);
            if (r_cnt == c_LAST) begin
                r_cnt       <= '0;
                r_y         <= w_prod_next[WIDTH-1:0];
                r_y_hi      <= w_prod_next[2*WIDTH-1:WIDTH];
                r_cout      <= 1'b0;
                r_neg       <= 1'b0;
                r_zero      <= (w_prod_next == '0);
                r_out_valid <= 1'b1;
                r_state     <= c_IDLE;
            end
        end
        else if (w_accept && op[4]) begin
            r_mcand     <= a;
            r_prod      <= {{WIDTH{1'b0}}, b};
            r_cnt       <= '0;
            r_out_valid <= 1'b0;
            r_state     <= c_MUL;
        end
`endif
        else if (w_accept) begin
            r_y         <= w_basic_y;
            r_cout      <= w_basic_cout;
            r_neg       <= w_basic_neg;
            r_zero      <= (w_basic_y == '0);
            r_out_valid <= 1'b1;
`ifdef ALU_SEQ_MUL_EN
            r_y_hi      <= '0;
`endif
        end
        else if (w_consume) begin
            r_out_valid <= 1'b0;
        end
    end

    assign y         = r_y;
    assign cout      = r_cout;
    assign neg       = r_neg;
    assign zero      = r_zero;
    assign out_valid = r_out_valid;

endmodule
`default_nettype wire

// File: tb/tb_alu_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_seq
//  Description : Self-checking bench for alu_seq (WIDTH=8). A transaction
//                model built from plain arithmetic predicts out_valid,
//                in_ready and the result every cycle; directed operations
//                pin the model with literal expectations, then a random
//                phase exercises handshakes, multiplies and resets.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_seq;

    localparam int W  = 8;
    localparam int W2 = 2 * W;
`ifdef ALU_SEQ_MUL_EN
    localparam bit MUL_EN = 1'b1;
`else
    localparam bit MUL_EN = 1'b0;
`endif

    logic         clk       = 1'b0;
    logic         rst       = 1'b1;
    logic         in_valid  = 1'b0;
    logic         out_ready = 1'b1;
    logic [4:0]   op        = '0;
    logic [W-1:0] a         = '0;
    logic [W-1:0] b         = '0;
    logic         in_ready;
    logic         out_valid;
    logic [W-1:0] y;
    logic [W-1:0] y_hi;
    logic         cout;
    logic         neg;
    logic         zero;

    int checks = 0;
    int errors = 0;

    alu_seq #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y         (y),
        .y_hi      (y_hi),
        .cout      (cout),
        .neg       (neg),
        .zero      (zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: what the block must hold after each edge
    // ------------------------------------------------------------------
    logic          m_valid = 1'b0;
    logic [W-1:0]  m_y     = '0;
    logic [W-1:0]  m_yhi   = '0;
    logic          m_cout  = 1'b0;
    logic          m_neg   = 1'b0;
    logic          m_zero  = 1'b0;
    int            m_busy  = 0;
    logic [W2-1:0] m_prod  = '0;

    initial begin : model_compare
        logic [W-1:0] am, bm, r;
        int total;
        forever begin
            @(posedge clk);
            if (rst) begin
                m_valid = 0; m_y = 0; m_yhi = 0; m_cout = 0; m_neg = 0; m_zero = 0;
                m_busy  = 0;
            end else if (m_busy > 0) begin
                m_busy--;
                if (m_busy == 0) begin
                    m_valid = 1;
                    m_y     = m_prod[W-1:0];
                    m_yhi   = m_prod[W2-1:W];
                    m_cout  = 0;
                    m_neg   = 0;
                    m_zero  = (m_prod == 0);
                end
            end else if (in_valid && (!m_valid || out_ready)) begin
                if (MUL_EN && op[4]) begin
                    m_busy  = W;
                    m_valid = 0;
                    m_prod  = W2'(a) * W2'(b);
                end else begin
                    am    = op[3] ? ~a : a;
                    bm    = op[2] ? ~b : b;
                    total = int'(am) + int'(bm) + int'(op[2]);
                    case (op[1:0])
                        2'd0:    r = am & bm;
                        2'd1:    r = am | bm;
                        2'd2:    r = am ^ bm;
                        default: r = W'(total);
                    endcase
                    m_valid = 1;
                    m_y     = r;
                    m_yhi   = 0;
                    m_cout  = (op[1:0] == 2'd3) && (total >= (1 << W));
                    m_neg   = (op[1:0] == 2'd3) && op[2] && (total < (1 << W));
                    m_zero  = (r == 0);
                end
            end else if (m_valid && out_ready) begin
                m_valid = 0;
            end
            #1;
            chk("model_out_valid", 32'(out_valid), 32'(m_valid));
            chk("model_in_ready", 32'(in_ready), 32'((m_busy == 0) && (!m_valid || out_ready)));
            if (m_valid) begin
                chk("model_y", 32'(y), 32'(m_y));
                chk("model_y_hi", 32'(y_hi), 32'(m_yhi));
                chk("model_cout", 32'(cout), 32'(m_cout));
                chk("model_neg", 32'(neg), 32'(m_neg));
                chk("model_zero", 32'(zero), 32'(m_zero));
            end
        end
    end

    // ------------------------------------------------------------------
    // Directed helpers (called just after a falling edge)
    // ------------------------------------------------------------------
    task automatic send(input logic [4:0] t_op, input logic [W-1:0] t_a, input logic [W-1:0] t_b);
        int n = 0;
        op = t_op; a = t_a; b = t_b; in_valid = 1'b1;
        #1;
        while (!in_ready && n < 40) begin
            @(negedge clk); #1;
            n++;
        end
        if (!in_ready) begin
            checks++; errors++;
            $display("FAIL send_timeout actual=in_ready_low required=accept at %0t", $time);
        end
        @(posedge clk); #1;
    endtask

    task automatic wait_result();
        int n = 0;
        @(negedge clk);
        in_valid = 1'b0;
        while (!out_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!out_valid) begin
            checks++; errors++;
            $display("FAIL result_timeout actual=out_valid_low required=out_valid_high at %0t", $time);
        end
    endtask

    task automatic expect_res(input string nm, input logic [W-1:0] ey, input logic [W-1:0] eyhi,
                              input logic ec, input logic en, input logic ez);
        chk({nm, "_y"},    32'(y),    32'(ey));
        chk({nm, "_y_hi"}, 32'(y_hi), 32'(eyhi));
        chk({nm, "_cout"}, 32'(cout), 32'(ec));
        chk({nm, "_neg"},  32'(neg),  32'(en));
        chk({nm, "_zero"}, 32'(zero), 32'(ez));
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog actual=running required=finished at %0t", $time);
        $fatal(1, "bench timed out");
    end

    initial begin : stimulus
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_out_valid", 32'(out_valid), 32'(0));
        expect_res("reset", 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        #1;
        chk("reset_in_ready", 32'(in_ready), 32'(1));

        // Add, subtract both ways, xor to zero, inverted-a and
        @(negedge clk); send(5'b00011, 8'h7F, 8'h01); wait_result();
        expect_res("add", 8'h80, 8'h00, 1'b0, 1'b0, 1'b0);
        @(negedge clk); send(5'b00111, 8'h03, 8'h05); wait_result();
        expect_res("sub_neg", 8'hFE, 8'h00, 1'b0, 1'b1, 1'b0);
        @(negedge clk); send(5'b00111, 8'h05, 8'h03); wait_result();
        expect_res("sub_pos", 8'h02, 8'h00, 1'b1, 1'b0, 1'b0);
        @(negedge clk); send(5'b00010, 8'hA5, 8'hA5); wait_result();
        expect_res("xor_zero", 8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
        @(negedge clk); send(5'b01000, 8'h0F, 8'h33); wait_result();
        expect_res("nand_a", 8'h30, 8'h00, 1'b0, 1'b0, 1'b0);

        // Multiply FF*FF (or AND when the multiplier is absent)
        @(negedge clk); send(5'b10000, 8'hFF, 8'hFF);
`ifdef ALU_SEQ_MUL_EN
        for (int i = 0; i < W; i++) begin
            @(negedge clk);
            in_valid = 1'b0;
            chk("mul_busy_in_ready", 32'(in_ready), 32'(0));
            chk("mul_busy_out_valid", 32'(out_valid), 32'(0));
        end
        @(negedge clk);
        chk("mul_out_valid", 32'(out_valid), 32'(1));
        expect_res("mul", 8'h01, 8'hFE, 1'b0, 1'b0, 1'b0);
`else
        wait_result();
        expect_res("mul_off_and", 8'hFF, 8'h00, 1'b0, 1'b0, 1'b0);
`endif

        // Backpressure, then consume and accept in the same cycle
        repeat (2) @(negedge clk);
        out_ready = 1'b0;
        send(5'b00011, 8'h10, 8'h20);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            in_valid = 1'b0;
            chk("bp_out_valid", 32'(out_valid), 32'(1));
            chk("bp_y", 32'(y), 32'(8'h30));
            chk("bp_in_ready", 32'(in_ready), 32'(0));
        end
        out_ready = 1'b1;
        send(5'b00011, 8'h01, 8'h01);
        @(negedge clk);
        in_valid = 1'b0;
        chk("bp_next_valid", 32'(out_valid), 32'(1));
        chk("bp_next_y", 32'(y), 32'(8'h02));

        // Reset during the third multiply cycle
        repeat (2) @(negedge clk);
        send(5'b10000, 8'h12, 8'h34);
        @(negedge clk); in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk); rst = 1'b1;
        @(negedge clk);
        chk("rst_mul_out_valid", 32'(out_valid), 32'(0));
        expect_res("rst_mul", 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        #1;
        chk("rst_mul_in_ready", 32'(in_ready), 32'(1));
        repeat (12) @(negedge clk);
        chk("rst_mul_no_result", 32'(out_valid), 32'(0));

        // Random traffic checked by the model
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            rst       = ($urandom_range(0, 99) == 0);
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            op        = 5'($urandom);
            a         = ($urandom_range(0, 7) == 0) ? 8'hFF : 8'($urandom);
            b         = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
        end
        @(negedge clk);
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        repeat (20) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
